imem_responder: RTL

- Responder end of the instruction-fetch interface: accepts fetch requests (word address), returns 16-bit instruction words over a valid/ready response channel after a fixed read latency.
- Owns the instruction memory array and a program-load write port used by the bench/boot loader.
- Sits between the fetch stage (initiator) and the instruction store. Absorbs fetch back-pressure with a small response FIFO and credit-based request flow control.

---
 rtl/imem_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction memory with latency pipe, response FIFO and credit flow control; IMEM_PARITY_EN adds stored parity
module imem_responder #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
`ifdef IMEM_PARITY_EN
  ,
  input  logic              load_par_flip,
  output logic              rsp_perr
`endif
);
`ifdef IMEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [MW-1:0]     mem_q [2**ADDR_W];
  logic [MW-1:0]     ld_word;
  logic [LATENCY-1:0] pipe_v_q, pipe_v_d;
  logic [LATENCY:0]  pipe_v_sh;
  logic [MW-1:0]     pipe_d_q [LATENCY];
  logic [ADDR_W-1:0] pipe_a_q [LATENCY];
  logic [MW-1:0]     fifo_d_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_a_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d, cr_q, cr_d;
  logic              accept, push, pop;
`ifdef IMEM_PARITY_EN
  assign ld_word  = {(^load_data) ^ load_par_flip, load_data};
  assign rsp_perr = fifo_d_q[rd_q][DATA_W] ^ (^fifo_d_q[rd_q][DATA_W-1:0]);
`else
  assign ld_word  = load_data;
`endif
  always_comb begin
    req_ready = !reset && !load_en && (cr_q != '0);
    accept    = req_valid && req_ready;
    push      = pipe_v_q[LATENCY-1];
    rsp_valid = cnt_q != '0;
    pop       = rsp_valid && rsp_ready;
    rsp_data  = fifo_d_q[rd_q][DATA_W-1:0];
    rsp_addr  = fifo_a_q[rd_q];
    busy      = (pipe_v_q != '0) || (cnt_q != '0);
    pipe_v_sh = {pipe_v_q, accept};
    pipe_v_d  = pipe_v_sh[LATENCY-1:0];
    wr_d      = push ? (wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d      = pop ? (rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    cr_d      = cr_q - CW'(accept) + CW'(pop);
  end
  always_ff @(posedge clock) begin
    if (load_en) mem_q[load_addr] <= ld_word;
  end
  // Data path is unreset: only the valid bits decide what reaches the FIFO.
  always_ff @(posedge clock) begin
    pipe_d_q[0] <= mem_q[req_addr];
    pipe_a_q[0] <= req_addr;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d_q[i] <= pipe_d_q[i-1];
      pipe_a_q[i] <= pipe_a_q[i-1];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_v_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      cr_q     <= CW'(FIFO_DEPTH);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_d_q[i] <= '0;
        fifo_a_q[i] <= '0;
      end
    end else begin
      pipe_v_q <= pipe_v_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      cr_q     <= cr_d;
      if (push) begin
        fifo_d_q[wr_q] <= pipe_d_q[LATENCY-1];
        fifo_a_q[wr_q] <= pipe_a_q[LATENCY-1];
      end
    end
  end
endmodule
